// File: rtl/return_stack_pkg.sv
// Shared constants and FSM encoding for the CPU return-address stack.
// PC_WIDTH matches the program counter and its incrementer.
package return_stack_pkg;

    localparam int PC_WIDTH     = 10;
    localparam int RSTACK_DEPTH = 8;

    typedef enum logic {
        RS_RUN = 1'b0,
        RS_ERR = 1'b1
    } rs_state_e;

endpackage

// File: rtl/return_stack_if.sv
// Call/return request and status bundle between the CPU core and the return stack.
// The core is the master, and the stack is the slave.
interface return_stack_if
    import return_stack_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH,
    parameter int DEPTH = RSTACK_DEPTH
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             push;
    logic             pop;
    logic             clear;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    modport master (
        output push, pop, clear, d,
        input  q, count, empty, full, overflow, underflow
    );

    modport slave (
        input  push, pop, clear, d,
        output q, count, empty, full, overflow, underflow
    );

endinterface

// File: rtl/return_stack.sv
// LIFO return-address stack with a registered top, an occupancy count, and sticky errors.
// Any illegal request freezes the stack in ERR until clear or reset.
module return_stack
    import return_stack_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH,
    parameter int DEPTH = RSTACK_DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    return_stack_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    rs_state_e        state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] top_q, top_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             mem_we;
    logic [IW-1:0]    mem_waddr;
    logic [IW-1:0]    rd_idx;

    // The refill index is count-2. It is used only when count >= 2, so it stays within 0..DEPTH-1.
    assign rd_idx = IW'(count_q - CW'(2));

    // NOTE: every variable gets a default before any branch, so no latches are inferred.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        top_d     = top_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        mem_we    = 1'b0;
        mem_waddr = IW'(count_q);

        if (bus.clear) begin
            state_d = RS_RUN;
            count_d = '0;
            top_d   = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else if (state_q == RS_RUN) begin
            if (bus.push && bus.pop) begin
                if (count_q != '0) begin
                    mem_we    = 1'b1;
                    mem_waddr = IW'(count_q - CW'(1));
                    top_d     = bus.d;
                end else begin
                    unf_d   = 1'b1;
                    state_d = RS_ERR;
                end
            end else if (bus.push) begin
                if (count_q < CW'(DEPTH)) begin
                    mem_we  = 1'b1;
                    top_d   = bus.d;
                    count_d = count_q + CW'(1);
                end else begin
                    ovf_d   = 1'b1;
                    state_d = RS_ERR;
                end
            end else if (bus.pop) begin
                if (count_q != '0) begin
                    count_d = count_q - CW'(1);
                    top_d   = (count_q >= CW'(2)) ? mem_q[rd_idx] : '0;
                end else begin
                    unf_d   = 1'b1;
                    state_d = RS_ERR;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RS_RUN;
            count_q <= '0;
            top_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            top_q   <= top_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // NOTE: storage is deliberately not reset; an entry is read only after it has been written.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= bus.d;
        end
    end

    assign bus.q         = top_q;
    assign bus.count     = count_q;
    assign bus.empty     = (count_q == '0);
    assign bus.full      = (count_q == CW'(DEPTH));
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;

endmodule

// File: tb/tb_return_stack.sv
// Directed bench for return_stack: push/pop sequencing, overflow/underflow freeze, clear, and reset priority.
module tb_return_stack;

    localparam int WIDTH = 10;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    return_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    return_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Apply one cycle of inputs, then return 1 time unit after the sampling edge.
    task automatic step(input logic rst, input logic psh, input logic pp,
                        input logic clr, input logic [WIDTH-1:0] din);
        reset     = rst;
        bus.push  = psh;
        bus.pop   = pp;
        bus.clear = clr;
        bus.d     = din;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [WIDTH-1:0] eq, input int ecount,
                             input logic ee, input logic ef, input logic eo, input logic eu);
        check({tag, ".q"},         32'(bus.q),         32'(eq));
        check({tag, ".count"},     32'(bus.count),     32'(ecount));
        check({tag, ".empty"},     32'(bus.empty),     32'(ee));
        check({tag, ".full"},      32'(bus.full),      32'(ef));
        check({tag, ".overflow"},  32'(bus.overflow),  32'(eo));
        check({tag, ".underflow"}, 32'(bus.underflow), 32'(eu));
    endtask

    initial begin
        // Reset
        step(1, 0, 0, 0, '0);
        step(1, 1, 0, 0, 10'h2AA);
        check_all("reset", 10'h000, 0, 1, 0, 0, 0);

        // Three pushes
        step(0, 1, 0, 0, 10'h005);
        check_all("push1", 10'h005, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 10'h010);
        step(0, 1, 0, 0, 10'h3FF);
        check_all("push3", 10'h3FF, 3, 0, 0, 0, 0);

        // Three pops, then an idle cycle that must hold
        step(0, 0, 1, 0, '0);
        check_all("pop1", 10'h010, 2, 0, 0, 0, 0);
        step(0, 0, 1, 0, '0);
        check_all("pop2", 10'h005, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, '0);
        check_all("pop3", 10'h000, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 10'h1FF);
        check_all("idle", 10'h000, 0, 1, 0, 0, 0);

        // Fill to DEPTH, then check the deep refill and the overflow freeze
        for (int i = 1; i <= DEPTH; i++) step(0, 1, 0, 0, 10'(10'h100 + i));
        check_all("fill8", 10'h108, 8, 0, 1, 0, 0);
        step(0, 0, 1, 0, '0);
        check_all("pop_from_full", 10'h107, 7, 0, 0, 0, 0);
        step(0, 1, 0, 0, 10'h108);
        check_all("refill8", 10'h108, 8, 0, 1, 0, 0);
        step(0, 1, 0, 0, 10'h123);
        check_all("overflow", 10'h108, 8, 0, 1, 1, 0);
        step(0, 1, 0, 0, 10'h055);
        check_all("err_push_ignored", 10'h108, 8, 0, 1, 1, 0);
        step(0, 0, 1, 0, '0);
        check_all("err_pop_ignored", 10'h108, 8, 0, 1, 1, 0);
        step(0, 1, 0, 1, 10'h066);
        check_all("clear_ovf", 10'h000, 0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 10'h077);
        check_all("run_after_clear", 10'h077, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, '0);
        check_all("pop_to_empty", 10'h000, 0, 1, 0, 0, 0);

        // Underflow on an empty stack
        step(0, 0, 1, 0, '0);
        check_all("underflow", 10'h000, 0, 1, 0, 0, 1);
        step(0, 1, 0, 0, 10'h001);
        check_all("unf_push_ignored", 10'h000, 0, 1, 0, 0, 1);
        step(0, 0, 0, 1, '0);
        check_all("clear_unf", 10'h000, 0, 1, 0, 0, 0);

        // Simultaneous push and pop on an empty stack is an underflow
        step(0, 1, 1, 0, 10'h0BB);
        check_all("pushpop_empty", 10'h000, 0, 1, 0, 0, 1);
        step(0, 0, 0, 1, '0);
        check_all("clear_pp", 10'h000, 0, 1, 0, 0, 0);

        // Replace the top with push and pop, then restore the first entry with a pop
        step(0, 1, 0, 0, 10'h011);
        step(0, 1, 0, 0, 10'h020);
        check_all("two_entries", 10'h020, 2, 0, 0, 0, 0);
        step(0, 1, 1, 0, 10'h0AA);
        check_all("replace_top", 10'h0AA, 2, 0, 0, 0, 0);
        step(0, 0, 1, 0, '0);
        check_all("pop_after_replace", 10'h011, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, '0);
        check_all("pop_last", 10'h000, 0, 1, 0, 0, 0);

        // Replacing the top must leave the lower entry untouched
        step(0, 1, 0, 0, 10'h031);
        step(0, 1, 0, 0, 10'h032);
        step(0, 1, 1, 0, 10'h033);
        step(0, 1, 1, 0, 10'h034);
        check_all("replace_twice", 10'h034, 2, 0, 0, 0, 0);
        step(0, 0, 1, 0, '0);
        check_all("lower_intact", 10'h031, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, '0);

        // Reset wins over a pending push
        for (int i = 1; i <= 5; i++) step(0, 1, 0, 0, 10'(i));
        check_all("count5", 10'h005, 5, 0, 0, 0, 0);
        step(1, 1, 0, 0, 10'h003);
        check_all("reset_mid", 10'h000, 0, 1, 0, 0, 0);

        // Reset with clear set, entered from the ERR state
        step(0, 1, 0, 0, 10'h0F0);
        step(0, 0, 1, 0, '0);
        step(0, 0, 1, 0, '0);
        check_all("unf_before_reset", 10'h000, 0, 1, 0, 0, 1);
        step(1, 1, 0, 1, 10'h0F1);
        check_all("reset_and_clear", 10'h000, 0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 10'h0F2);
        check_all("run_after_reset", 10'h0F2, 1, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
